hv_fault_ctrl: RTL and testbench
================================

Name: hv_fault_ctrl

Overview:
- HV-side gate-drive fault controller.
- Sequences the gate command through turn-on, desat blanking, on-time, two-level (TLT) soft turn-off and latched fault.
- Qualifies SCP, DESAT and OCP comparator outputs using the config6/8/9 deglitch and blanking fields and the config4 tltoff fields from the HV register file.
- Sits between the HV register block and the analog driver stage.

Parameters:
- BLANK_UNIT, 16, clk cycles per desat_blanking LSB
- DGL_UNIT, 4, clk cycles per deglitch_sel LSB
- TLT_UNIT, 32, clk cycles per t_tltoff LSB
- CNT_W, 10, shared timer width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- pwm_in  in  1  gate request from LV link (1 = on)
- scp_cmp, desat_cmp, ocp_cmp  in  1 each  async analog comparator outputs
- desat_dig_en, ocp_dig_en, scp_dig_en  in  1 each  per-fault enables
- desat_blanking  in  3  blanking select
- desat_deglitch_sel, ocp_deglitch_sel, scp_deglitch_sel  in  3 each  deglitch selects
- tlt_sof_sel  in  1  1 = soft two-level turn-off on fault
- t_tltoff  in  2  TLT duration select
- fault_clr  in  1  single-cycle clear pulse
- gate_cmd  out  2  00 OFF, 01 ON, 10 TLT
- fault_flag  out  1  latched fault
- fault_type  out  2  0 none, 1 OCP, 2 DESAT, 3 SCP

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state OFF, gate_cmd=00, fault_flag=0, fault_type=0, all counters 0, synchronizers 0.
- Synchronizers: each comparator passes a 2-flop synchronizer.
- Deglitch:
  - Counter clears whenever the synced input is low or the enable is 0.
  - Qualified when the count reaches N=(sel+1)*DGL_UNIT, then holds while the input stays high.
  - SCP and OCP counters run only while gate_cmd=ON.
  - DESAT counter runs only in state ON (post-blank).
  - Latency: gate_cmd changes at clk edge 2+N+1 after the first edge sampling the comparator high.
- FSM states: OFF, BLANK, ON, TLT, FAULT.
  - OFF: gate_cmd=00. pwm_in=1 -> BLANK; timer loads (desat_blanking+1)*BLANK_UNIT, sampled at entry.
  - BLANK: gate_cmd=01; timer decrements. pwm_in=0 -> OFF. Timer reaches 0 -> ON. SCP/OCP are active; DESAT is ignored.
  - ON: gate_cmd=01. pwm_in=0 -> OFF.
  - Fault qualified in BLANK or ON:
    - tlt_sof_sel=1 -> TLT; timer loads (t_tltoff+1)*TLT_UNIT.
    - tlt_sof_sel=0 -> FAULT.
    - tlt_sof_sel and t_tltoff are latched at fault entry.
    - fault_flag and fault_type are set on the same edge.
  - TLT: gate_cmd=10; pwm_in ignored; timer reaches 0 -> FAULT.
  - FAULT: gate_cmd=00. fault_clr with pwm_in=0 -> OFF and clears fault_flag/type. fault_clr with pwm_in=1 is ignored.
- Boundaries:
  - Simultaneous qualifications: priority SCP > DESAT > OCP.
  - Fault and pwm_in falling in the same cycle: fault wins.
  - Faults qualifying during TLT or FAULT do not change fault_type.
  - fault_clr outside FAULT has no effect.
  - rst mid-TLT returns to the reset state immediately.
  - Deglitch sel changes take effect live; a count already at or above the new N qualifies next cycle.

Optional Feature:
- Macro: HV_FAULT_CNT_EN.
- With the macro: add output fault_cnt (8 bits).
  - Increments on each BLANK/ON -> TLT/FAULT transition and saturates at 255.
  - Cleared only by rst.
- Without the macro: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- hv_pkg gains:
  - typedef enum hv_fault_st_e {OFF, BLANK, ON, TLT, FAULT}
  - typedef enum hv_gate_cmd_e
  - typedef enum hv_fault_type_e
  - localparams for the default units
- Sub-module hv_flt_dgl: synchronizer plus deglitch counter with enable, sel and qualified output; instantiated three times.

Test Plan:
- Reset, then pwm_in=1, desat_blanking=2: gate_cmd=01 from the next edge; state ON after 48 cycles; pwm_in=0 -> gate_cmd=00 next edge.
- In ON, desat_cmp high 40 cycles, desat_deglitch_sel=1 (N=8), tlt_sof_sel=1, t_tltoff=1:
  - gate_cmd=10 at edge 11;
  - then 64 cycles later gate_cmd=00, fault_flag=1, fault_type=2.
- In ON, ocp_cmp high for 7 cycles then low, ocp_deglitch_sel=1: no fault; gate_cmd stays 01.
- scp_cmp and ocp_cmp qualify the same cycle during BLANK, tlt_sof_sel=0: direct FAULT, fault_type=3.
- FAULT with pwm_in=1 and fault_clr pulse: stays FAULT. pwm_in=0 plus fault_clr: OFF, flag cleared.
- HV_FAULT_CNT_EN defined: 300 fault/clear cycles -> fault_cnt=255; rst -> 0.

Source files
------------

// File: rtl/hv_pkg.sv
// hv_pkg: shared types and default timing units for the HV fault controller.
// The optional fault counter is enabled by defining HV_FAULT_CNT_EN.
package hv_pkg;

    localparam int BLANK_UNIT_DEF = 16;
    localparam int DGL_UNIT_DEF   = 4;
    localparam int TLT_UNIT_DEF   = 32;
    localparam int CNT_W_DEF      = 10;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_BLANK = 3'd1,
        ST_ON    = 3'd2,
        ST_TLT   = 3'd3,
        ST_FAULT = 3'd4
    } hv_fault_st_e;

    typedef enum logic [1:0] {
        GATE_OFF = 2'b00,
        GATE_ON  = 2'b01,
        GATE_TLT = 2'b10
    } hv_gate_cmd_e;

    typedef enum logic [1:0] {
        FT_NONE  = 2'd0,
        FT_OCP   = 2'd1,
        FT_DESAT = 2'd2,
        FT_SCP   = 2'd3
    } hv_fault_type_e;

    // Register fields encode "value minus one", so a select of 0 is one unit.
    function automatic int hv_units(input int sel, input int unit);
        return (sel + 1) * unit;
    endfunction

endpackage

// File: rtl/hv_flt_dgl.sv
// hv_flt_dgl: two-flop synchronizer plus deglitch counter for one analog
// comparator. qual_o is asserted while the synced input has been high for at
// least (sel_i+1)*DGL_UNIT consecutive cycles with en_i and run_i both set.
module hv_flt_dgl
    import hv_pkg::*;
#(
    parameter int DGL_UNIT = DGL_UNIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmp_i,
    input  logic       en_i,
    input  logic       run_i,
    input  logic [2:0] sel_i,
    output logic       qual_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lim;

    // Threshold follows sel_i live; a count already past a lowered
    // threshold qualifies straight away.
    assign lim = CNT_W'(hv_units(int'(sel_i), DGL_UNIT));

    // Bring the asynchronous comparator into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cmp_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive high cycles, clear when idle, saturate at threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q || !en_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q < lim) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Deglitch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign qual_o = sync2_q && en_i && run_i && (cnt_q >= lim);

endmodule

// File: rtl/hv_fault_ctrl.sv
// hv_fault_ctrl: HV-side gate-drive sequencer. Walks the gate through
// OFF -> BLANK -> ON, and on a qualified SCP/DESAT/OCP fault either goes
// straight to a latched FAULT or through a timed two-level turn-off (TLT).
// Optional: define HV_FAULT_CNT_EN to add the saturating fault_cnt output.
module hv_fault_ctrl
    import hv_pkg::*;
#(
    parameter int BLANK_UNIT = BLANK_UNIT_DEF,
    parameter int DGL_UNIT   = DGL_UNIT_DEF,
    parameter int TLT_UNIT   = TLT_UNIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    input  logic         scp_cmp,
    input  logic         desat_cmp,
    input  logic         ocp_cmp,
    input  logic         desat_dig_en,
    input  logic         ocp_dig_en,
    input  logic         scp_dig_en,
    input  logic [2:0]   desat_blanking,
    input  logic [2:0]   desat_deglitch_sel,
    input  logic [2:0]   ocp_deglitch_sel,
    input  logic [2:0]   scp_deglitch_sel,
    input  logic         tlt_sof_sel,
    input  logic [1:0]   t_tltoff,
    input  logic         fault_clr,
    output logic [1:0]   gate_cmd,
    output logic         fault_flag,
    output logic [1:0]   fault_type,
    output hv_fault_st_e fsm_state
`ifdef HV_FAULT_CNT_EN
    ,
    output logic [7:0]   fault_cnt
`endif
);

    hv_fault_st_e   state_q;
    hv_gate_cmd_e   gate_q;
    hv_fault_type_e type_q;
    logic           flag_q;
    logic [CNT_W-1:0] timer_q;

    logic           scp_qual;
    logic           desat_qual;
    logic           ocp_qual;
    logic           run_gate;
    logic           run_desat;
    logic           fault_hit;
    logic           fault_enter;
    hv_fault_type_e hit_type;
    logic [CNT_W-1:0] blank_len;
    logic [CNT_W-1:0] tlt_len;

    // SCP/OCP watch the whole conducting interval; DESAT only after blanking.
    assign run_gate  = (gate_q == GATE_ON);
    assign run_desat = (state_q == ST_ON);

    hv_flt_dgl #(.DGL_UNIT(DGL_UNIT), .CNT_W(CNT_W)) u_scp_dgl (
        .clk(clk), .rst(rst), .cmp_i(scp_cmp), .en_i(scp_dig_en),
        .run_i(run_gate), .sel_i(scp_deglitch_sel), .qual_o(scp_qual)
    );

    hv_flt_dgl #(.DGL_UNIT(DGL_UNIT), .CNT_W(CNT_W)) u_desat_dgl (
        .clk(clk), .rst(rst), .cmp_i(desat_cmp), .en_i(desat_dig_en),
        .run_i(run_desat), .sel_i(desat_deglitch_sel), .qual_o(desat_qual)
    );

    hv_flt_dgl #(.DGL_UNIT(DGL_UNIT), .CNT_W(CNT_W)) u_ocp_dgl (
        .clk(clk), .rst(rst), .cmp_i(ocp_cmp), .en_i(ocp_dig_en),
        .run_i(run_gate), .sel_i(ocp_deglitch_sel), .qual_o(ocp_qual)
    );

    assign fault_hit   = scp_qual || desat_qual || ocp_qual;
    assign fault_enter = fault_hit && ((state_q == ST_BLANK) || (state_q == ST_ON));
    assign blank_len   = CNT_W'(hv_units(int'(desat_blanking), BLANK_UNIT));
    assign tlt_len     = CNT_W'(hv_units(int'(t_tltoff), TLT_UNIT));

    // Resolve simultaneous qualifications: SCP over DESAT over OCP.
    always_comb begin
        hit_type = FT_OCP;
        if (scp_qual) begin
            hit_type = FT_SCP;
        end else if (desat_qual) begin
            hit_type = FT_DESAT;
        end
    end

    // Gate sequencing FSM with registered gate command and fault status.
    // Timed states end on the edge where the timer would hit zero, so a load
    // of L keeps the state for exactly L cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            gate_q  <= GATE_OFF;
            type_q  <= FT_NONE;
            flag_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (pwm_in) begin
                        state_q <= ST_BLANK;
                        gate_q  <= GATE_ON;
                        timer_q <= blank_len;
                    end
                end
                ST_BLANK, ST_ON: begin
                    // A fault beats a falling pwm_in in the same cycle.
                    if (fault_hit) begin
                        flag_q <= 1'b1;
                        type_q <= hit_type;
                        if (tlt_sof_sel) begin
                            state_q <= ST_TLT;
                            gate_q  <= GATE_TLT;
                            timer_q <= tlt_len;
                        end else begin
                            state_q <= ST_FAULT;
                            gate_q  <= GATE_OFF;
                            timer_q <= '0;
                        end
                    end else if (!pwm_in) begin
                        state_q <= ST_OFF;
                        gate_q  <= GATE_OFF;
                        timer_q <= '0;
                    end else if (state_q == ST_BLANK) begin
                        if (timer_q <= CNT_W'(1)) begin
                            state_q <= ST_ON;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                end
                ST_TLT: begin
                    if (timer_q <= CNT_W'(1)) begin
                        state_q <= ST_FAULT;
                        gate_q  <= GATE_OFF;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Clearing is refused while the LV side still requests on.
                    if (fault_clr && !pwm_in) begin
                        state_q <= ST_OFF;
                        flag_q  <= 1'b0;
                        type_q  <= FT_NONE;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    gate_q  <= GATE_OFF;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign gate_cmd   = gate_q;
    assign fault_flag = flag_q;
    assign fault_type = type_q;
    assign fsm_state  = state_q;

`ifdef HV_FAULT_CNT_EN
    logic [7:0] fcnt_q;

    // Saturating count of fault entries; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (fault_enter && (fcnt_q != 8'hFF)) begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign fault_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_hv_fault_ctrl.sv
// tb_hv_fault_ctrl: directed scenarios plus randomized episodes, every cycle
// compared against a behavioural model built from comparator run lengths and
// absolute deadline cycles.
`timescale 1ns/1ps
module tb_hv_fault_ctrl;
    import hv_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic pwm_in, scp_cmp, desat_cmp, ocp_cmp;
    logic desat_dig_en, ocp_dig_en, scp_dig_en;
    logic [2:0] desat_blanking, desat_deglitch_sel, ocp_deglitch_sel, scp_deglitch_sel;
    logic tlt_sof_sel;
    logic [1:0] t_tltoff;
    logic fault_clr;
    logic [1:0] gate_cmd;
    logic fault_flag;
    logic [1:0] fault_type;
    hv_fault_st_e fsm_state;
`ifdef HV_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    always #5 clk = ~clk;

    hv_fault_ctrl dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .scp_cmp(scp_cmp), .desat_cmp(desat_cmp), .ocp_cmp(ocp_cmp),
        .desat_dig_en(desat_dig_en), .ocp_dig_en(ocp_dig_en), .scp_dig_en(scp_dig_en),
        .desat_blanking(desat_blanking), .desat_deglitch_sel(desat_deglitch_sel),
        .ocp_deglitch_sel(ocp_deglitch_sel), .scp_deglitch_sel(scp_deglitch_sel),
        .tlt_sof_sel(tlt_sof_sel), .t_tltoff(t_tltoff), .fault_clr(fault_clr),
        .gate_cmd(gate_cmd), .fault_flag(fault_flag), .fault_type(fault_type),
        .fsm_state(fsm_state)
`ifdef HV_FAULT_CNT_EN
        , .fault_cnt(fault_cnt)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // index 0 = SCP, 1 = DESAT, 2 = OCP
    hv_fault_st_e m_st;
    int  m_until, m_type, m_cnt, cyc;
    bit  m_flag;
    bit  d1 [3];
    bit  d2 [3];
    int  streak [3];

    task automatic model_reset();
        m_st = ST_OFF; m_flag = 0; m_type = 0; m_cnt = 0; m_until = 0;
        for (int k = 0; k < 3; k++) begin d1[k] = 0; d2[k] = 0; streak[k] = 0; end
    endtask

    // One clock edge: inputs are the values present at that edge.
    task automatic model_step();
        bit cmp [3];
        bit en [3];
        int sel [3];
        bit q [3];
        bit run;
        cyc++;
        if (rst) begin model_reset(); return; end
        cmp[0] = scp_cmp;      cmp[1] = desat_cmp;          cmp[2] = ocp_cmp;
        en[0]  = scp_dig_en;   en[1]  = desat_dig_en;       en[2]  = ocp_dig_en;
        sel[0] = scp_deglitch_sel; sel[1] = desat_deglitch_sel; sel[2] = ocp_deglitch_sel;
        for (int k = 0; k < 3; k++) begin
            run = (k == 1) ? (m_st == ST_ON) : (m_st == ST_BLANK || m_st == ST_ON);
            q[k] = en[k] && run && d2[k] && (streak[k] >= (sel[k] + 1) * 4);
            streak[k] = (en[k] && run && d2[k]) ? streak[k] + 1 : 0;
            d2[k] = d1[k];
            d1[k] = cmp[k];
        end
        case (m_st)
            ST_OFF: if (pwm_in) begin m_st = ST_BLANK; m_until = cyc + (desat_blanking + 1) * 16; end
            ST_BLANK, ST_ON: begin
                if (q[0] || q[1] || q[2]) begin
                    m_flag = 1;
                    m_type = q[0] ? 3 : (q[1] ? 2 : 1);
                    if (m_cnt < 255) m_cnt++;
                    if (tlt_sof_sel) begin m_st = ST_TLT; m_until = cyc + (t_tltoff + 1) * 32; end
                    else m_st = ST_FAULT;
                end else if (!pwm_in) m_st = ST_OFF;
                else if (m_st == ST_BLANK && cyc == m_until) m_st = ST_ON;
            end
            ST_TLT: if (cyc == m_until) m_st = ST_FAULT;
            ST_FAULT: if (fault_clr && !pwm_in) begin m_st = ST_OFF; m_flag = 0; m_type = 0; end
            default: m_st = ST_OFF;
        endcase
    endtask

    function automatic logic [1:0] exp_gate(input hv_fault_st_e s);
        if (s == ST_BLANK || s == ST_ON) return 2'b01;
        if (s == ST_TLT) return 2'b10;
        return 2'b00;
    endfunction

    task automatic compare_all();
        check("gate_cmd", 32'(gate_cmd), 32'(exp_gate(m_st)));
        check("fault_flag", 32'(fault_flag), 32'(m_flag));
        check("fault_type", 32'(fault_type), 32'(m_type));
        check("fsm_state", 32'(fsm_state), 32'(m_st));
`ifdef HV_FAULT_CNT_EN
        check("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic wait_state(input hv_fault_st_e s, input int budget);
        for (int i = 0; i < budget && m_st != s; i++) tick(1);
        check("wait_state", 32'(fsm_state), 32'(s));
    endtask

    task automatic clear_fault();
        pwm_in = 0; fault_clr = 1; tick(1); fault_clr = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0; model_reset();
        rst = 1; pwm_in = 0; scp_cmp = 0; desat_cmp = 0; ocp_cmp = 0;
        desat_dig_en = 1; ocp_dig_en = 1; scp_dig_en = 1;
        desat_blanking = 3'd2; desat_deglitch_sel = 3'd1;
        ocp_deglitch_sel = 3'd1; scp_deglitch_sel = 3'd1;
        tlt_sof_sel = 1; t_tltoff = 2'd1; fault_clr = 0;
        tick(2);
        check("reset_gate", 32'(gate_cmd), 32'd0);
        check("reset_flag", 32'(fault_flag), 32'd0);
        check("reset_type", 32'(fault_type), 32'd0);
        rst = 0;

        // Turn-on, 48-cycle blanking, turn-off.
        pwm_in = 1; tick(1);
        check("t1_gate_on", 32'(gate_cmd), 32'd1);
        tick(47);
        check("t1_still_blank", 32'(fsm_state), 32'(ST_BLANK));
        tick(1);
        check("t1_on", 32'(fsm_state), 32'(ST_ON));
        pwm_in = 0; tick(1);
        check("t1_gate_off", 32'(gate_cmd), 32'd0);

        // DESAT with soft turn-off.
        pwm_in = 1; wait_state(ST_ON, 100);
        desat_cmp = 1; tick(10);
        check("t2_pre_tlt", 32'(gate_cmd), 32'd1);
        tick(1);
        check("t2_tlt_edge11", 32'(gate_cmd), 32'd2);
        tick(29); desat_cmp = 0; tick(34);
        check("t2_tlt_hold", 32'(gate_cmd), 32'd2);
        tick(1);
        check("t2_fault_gate", 32'(gate_cmd), 32'd0);
        check("t2_fault_flag", 32'(fault_flag), 32'd1);
        check("t2_fault_type", 32'(fault_type), 32'd2);
        clear_fault();
        check("t2_cleared", 32'(fault_flag), 32'd0);

        // Short OCP glitch is rejected.
        pwm_in = 1; wait_state(ST_ON, 100);
        ocp_cmp = 1; tick(7); ocp_cmp = 0; tick(10);
        check("t3_no_fault_gate", 32'(gate_cmd), 32'd1);
        check("t3_no_fault_flag", 32'(fault_flag), 32'd0);

        // SCP and OCP together in BLANK, hard turn-off.
        pwm_in = 0; tick(1); pwm_in = 1; tlt_sof_sel = 0; tick(1);
        scp_cmp = 1; ocp_cmp = 1; tick(11);
        check("t4_state", 32'(fsm_state), 32'(ST_FAULT));
        check("t4_type", 32'(fault_type), 32'd3);
        scp_cmp = 0; ocp_cmp = 0;

        // Clear refused while pwm_in high, accepted when low.
        fault_clr = 1; tick(1); fault_clr = 0;
        check("t5_stay_fault", 32'(fsm_state), 32'(ST_FAULT));
        check("t5_flag_kept", 32'(fault_flag), 32'd1);
        clear_fault();
        check("t5_off", 32'(fsm_state), 32'(ST_OFF));
        check("t5_flag_clr", 32'(fault_flag), 32'd0);

        // Reset in the middle of TLT.
        tlt_sof_sel = 1; pwm_in = 1; wait_state(ST_ON, 100);
        desat_cmp = 1; wait_state(ST_TLT, 30); tick(5);
        rst = 1; tick(1); rst = 0; desat_cmp = 0; pwm_in = 0;
        check("t6_rst_gate", 32'(gate_cmd), 32'd0);
        check("t6_rst_state", 32'(fsm_state), 32'(ST_OFF));
        tick(4);

`ifdef HV_FAULT_CNT_EN
        // Saturation of the fault counter.
        tlt_sof_sel = 0; scp_deglitch_sel = 0; desat_blanking = 0;
        for (int r = 0; r < 300; r++) begin
            pwm_in = 1; scp_cmp = 1;
            wait_state(ST_FAULT, 40);
            scp_cmp = 0; clear_fault();
        end
        check("cnt_sat", 32'(fault_cnt), 32'd255);
        rst = 1; tick(1); rst = 0;
        check("cnt_rst", 32'(fault_cnt), 32'd0);
`endif

        // Randomized episodes with fixed configuration per episode.
        for (int ep = 0; ep < 30; ep++) begin
            rst = 1; tick(1); rst = 0;
            scp_dig_en = ($urandom_range(0, 3) != 0);
            desat_dig_en = ($urandom_range(0, 3) != 0);
            ocp_dig_en = ($urandom_range(0, 3) != 0);
            desat_blanking = 3'($urandom_range(0, 7));
            scp_deglitch_sel = 3'($urandom_range(0, 7));
            desat_deglitch_sel = 3'($urandom_range(0, 7));
            ocp_deglitch_sel = 3'($urandom_range(0, 7));
            tlt_sof_sel = 1'($urandom_range(0, 1));
            t_tltoff = 2'($urandom_range(0, 3));
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 39) == 0) pwm_in = ~pwm_in;
                if ($urandom_range(0, 14) == 0) scp_cmp = ~scp_cmp;
                if ($urandom_range(0, 14) == 0) desat_cmp = ~desat_cmp;
                if ($urandom_range(0, 14) == 0) ocp_cmp = ~ocp_cmp;
                fault_clr = ($urandom_range(0, 15) == 0);
                rst = ($urandom_range(0, 499) == 0);
                tick(1);
            end
            rst = 0; fault_clr = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
